flit_serializer: RTL and testbench

- Upstream neighbour of the 6-flit extractor. It accepts one whole packet in parallel (head, 4 body, tail) over a valid/ready handshake and emits it as a continuous 16-bit flit stream, one flit per clock.
- The downstream extractor samples every cycle with no valid qualifier, and its slot counter is free-running from reset. This block therefore keeps a matching slot counter from the shared reset and always emits a full 6-flit frame.
- When no packet is available, the frame is filled with idle flits.

---
 rtl/flit_serializer.sv | 72 +++++++
 tb/tb_flit_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/flit_serializer.sv
// flit_serializer: turns one parallel 6-flit packet into a continuous 16-bit flit stream,
// with a slot counter that stays in step with the downstream extractor.
module flit_serializer #(
   parameter logic [15:0] IDLE_FLIT = 16'h0000,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [15:0]          i_head,
   input  logic [15:0]          i_body_1,
   input  logic [15:0]          i_body_2,
   input  logic [15:0]          i_body_3,
   input  logic [15:0]          i_body_4,
   input  logic [15:0]          i_tail,
   output logic [15:0]          o_flit,
   output logic                 o_sof,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_pkt_count
);
   logic [2:0]  r_slot;
   logic [15:0] frame [1:5];
   logic [15:0] pend [0:5];
   logic        pend_v;
   logic [15:0] in_pkt [0:5];
   logic [15:0] src [0:5];
   logic        boundary;
   logic        accept;
   assign boundary = r_slot == 3'd5;
   assign o_ready  = !pend_v || boundary;
   assign accept   = i_valid && o_ready;
   always_comb begin
      in_pkt[0] = i_head;
      in_pkt[1] = i_body_1;
      in_pkt[2] = i_body_2;
      in_pkt[3] = i_body_3;
      in_pkt[4] = i_body_4;
      in_pkt[5] = i_tail;
      // pending packet wins over a fresh offer, which wins over an idle frame
      for (int k = 0; k < 6; k++)
         src[k] = pend_v ? pend[k] : i_valid ? in_pkt[k] : IDLE_FLIT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot      <= 3'd0;
         o_flit      <= IDLE_FLIT;
         o_sof       <= 1'b1;
         o_busy      <= 1'b0;
         o_pkt_count <= '0;
         pend_v      <= 1'b0;
         for (int k = 1; k < 6; k++) frame[k] <= IDLE_FLIT;
      end else begin
         if (accept)
            for (int k = 0; k < 6; k++) pend[k] <= in_pkt[k];
         if (boundary) begin
            r_slot <= 3'd0;
            o_sof  <= 1'b1;
            o_flit <= src[0];
            o_busy <= pend_v || i_valid;
            pend_v <= pend_v && i_valid;
            for (int k = 1; k < 6; k++) frame[k] <= src[k];
            if (o_busy) o_pkt_count <= o_pkt_count + 1'b1;
         end else begin
            r_slot <= r_slot + 3'd1;
            o_sof  <= 1'b0;
            o_flit <= frame[r_slot + 3'd1];
            pend_v <= pend_v || accept;
         end
      end
   end
endmodule

// File: tb/tb_flit_serializer.sv
// tb_flit_serializer: random and directed stimulus against a queue-based frame model.
module tb_flit_serializer;
   typedef logic [5:0][15:0] pkt_t;
   logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0;
   logic [15:0] i_head = '0, i_body_1 = '0, i_body_2 = '0, i_body_3 = '0, i_body_4 = '0, i_tail = '0;
   logic        o_ready, o_sof, o_busy, r2, sof2, busy2;
   logic [15:0] o_flit, flit2, o_pkt_count;
   logic [1:0]  cnt2;
   pkt_t        q[$];
   pkt_t        cur = '0;
   int          m_slot = 0, m_cnt = 0, errors = 0, checks = 0;
   bit          m_busy = 1'b0, chk_en = 1'b0;
   always #5 clk = ~clk;
   flit_serializer dut (.clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_head(i_head), .i_body_1(i_body_1), .i_body_2(i_body_2), .i_body_3(i_body_3),
      .i_body_4(i_body_4), .i_tail(i_tail), .o_flit(o_flit), .o_sof(o_sof), .o_busy(o_busy),
      .o_pkt_count(o_pkt_count));
   flit_serializer #(.CNT_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(r2),
      .i_head(i_head), .i_body_1(i_body_1), .i_body_2(i_body_2), .i_body_3(i_body_3),
      .i_body_4(i_body_4), .i_tail(i_tail), .o_flit(flit2), .o_sof(sof2), .o_busy(busy2),
      .o_pkt_count(cnt2));
   function automatic pkt_t get_pkt();
      return {i_tail, i_body_4, i_body_3, i_body_2, i_body_1, i_head};
   endfunction
   function automatic pkt_t rnd_pkt();
      pkt_t p;
      for (int j = 0; j < 6; j++) p[j] = 16'($urandom);
      return p;
   endfunction
   task automatic set_pkt(input pkt_t p);
      i_head = p[0]; i_body_1 = p[1]; i_body_2 = p[2];
      i_body_3 = p[3]; i_body_4 = p[4]; i_tail = p[5];
   endtask
   task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task step();
      @(posedge clk);
      #1;
   endtask
   task wait_slot(input int s);
      for (int i = 0; i < 12 && m_slot != s; i++) step();
      chk("wait_slot", m_slot, s);
   endtask
   // Model: accepted packets queue up; each frame boundary pops one or goes idle.
   always @(posedge clk) begin
      if (rst) begin
         m_slot = 0; q.delete(); cur = '0; m_busy = 0; m_cnt = 0; chk_en = 1;
      end else begin
         if (i_valid && (q.size() == 0 || m_slot == 5)) q.push_back(get_pkt());
         if (m_slot == 5) begin
            if (m_busy) m_cnt++;
            if (q.size() > 0) begin
               cur = q.pop_front(); m_busy = 1;
            end else begin
               cur = '0; m_busy = 0;
            end
            m_slot = 0;
         end else m_slot++;
      end
   end
   always @(negedge clk) if (chk_en) begin
      chk("flit", o_flit, cur[m_slot]);
      chk("sof", o_sof, m_slot == 0);
      chk("busy", o_busy, m_busy);
      chk("count", o_pkt_count, m_cnt & 16'hffff);
      chk("ready", o_ready, q.size() == 0 || m_slot == 5);
      chk("flit2", flit2, cur[m_slot]);
      chk("count2", cnt2, m_cnt & 3);
   end
   initial begin
      #200000;
      $display("FAIL timeout: errors=%0d", errors);
      $fatal(1);
   end
   initial begin
      pkt_t pk;
      bit   r;
      int   n;
      int   exp2 [5] = '{1, 2, 3, 0, 1};
      pkt_t bp = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
      set_pkt(rnd_pkt());
      i_valid = 1;
      step(); step();
      chk("rst_flit", o_flit, 0); chk("rst_sof", o_sof, 1); chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_pkt_count, 0); chk("rst_ready", o_ready, 1);
      i_valid = 0; rst = 0;
      for (int k = 0; k < 18; k++) begin
         chk("idle_flit", o_flit, 0); chk("idle_sof", o_sof, (k % 6) == 0); chk("idle_busy", o_busy, 0);
         step();
      end
      chk("idle_cnt", o_pkt_count, 0);
      wait_slot(5);
      set_pkt(bp); i_valid = 1; step(); i_valid = 0;
      for (int k = 0; k < 6; k++) begin
         chk("byp_flit", o_flit, bp[k]);
         step();
      end
      chk("byp_cnt", o_pkt_count, 1);
      wait_slot(2);
      for (int p = 0; p < 3; p++) begin
         set_pkt(rnd_pkt()); i_valid = 1; n = 0;
         do begin r = o_ready; step(); n++; end while (!r && n < 20);
         chk("b2b_accept", r, 1);
         if (p == 0) chk("b2b_ready_low", o_ready, 0);
      end
      i_valid = 0;
      repeat (24) step();
      chk("b2b_cnt", o_pkt_count, 4);
      wait_slot(0);
      pk = rnd_pkt(); set_pkt(pk); i_valid = 1;
      chk("s0_ready", o_ready, 1);
      step(); i_valid = 0;
      repeat (4) step();
      chk("s0_pre_sof", o_sof, 0);
      step();
      chk("s0_sof", o_sof, 1); chk("s0_head", o_flit, pk[0]);
      wait_slot(5);
      set_pkt(rnd_pkt()); i_valid = 1; step();
      set_pkt(rnd_pkt()); step(); i_valid = 0;
      step(); step();
      chk("mid_busy_pre", o_busy, 1);
      rst = 1; step(); rst = 0;
      chk("mid_flit", o_flit, 0); chk("mid_busy", o_busy, 0); chk("mid_cnt", o_pkt_count, 0);
      chk("mid_sof", o_sof, 1); chk("mid_ready", o_ready, 1);
      repeat (7) step();
      chk("lost_busy", o_busy, 0);
      wait_slot(5);
      pk = rnd_pkt(); set_pkt(pk); i_valid = 1; step(); i_valid = 0;
      chk("realign_sof", o_sof, 1); chk("realign_head", o_flit, pk[0]);
      rst = 1; step(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         wait_slot(5);
         set_pkt(rnd_pkt()); i_valid = 1; step(); i_valid = 0;
         repeat (6) step();
         chk("cnt2_seq", cnt2, exp2[i]);
      end
      repeat (800) begin
         i_valid = $urandom_range(0, 3) != 0;
         set_pkt(rnd_pkt());
         rst = $urandom_range(0, 199) == 0;
         step();
      end
      rst = 0; i_valid = 0;
      repeat (12) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
